// File: rtl/mem_stage_access_ctrl.sv
// mem_stage_access_ctrl: M-stage load/store decode, req/ack data-memory handshake,
// pipeline stall, load formatting and misalignment/timeout exceptions.
module mem_stage_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       IR,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_wdata,
    output logic              dm_req,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [5:0]    op;
    logic          is_load, is_store, sz_h, sz_w, misal, idle, go, tmo;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n, shifted, fmt;
    logic [1:0]    lane, sz;
    logic          sgn, ld_op;
    logic [CW-1:0] cnt;
    logic          unused;

    assign unused   = ^IR[25:0];
    assign op       = IR[31:26];
    assign is_load  = op[5:3] == 3'b100 && (op[2:0] inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101});
    assign is_store = op[5:3] == 3'b101 && (op[2:0] inside {3'b000, 3'b001, 3'b011});
    assign sz_w     = op[1:0] == 2'b11;
    assign sz_h     = op[1:0] == 2'b01;
    assign misal    = sz_w ? |m_addr[1:0] : sz_h & m_addr[0];
    assign idle     = state == IDLE;
    assign go       = idle & m_valid & (is_load | is_store) & ~misal;
    assign exc_adel = idle & m_valid & is_load & misal;
    assign exc_ades = idle & m_valid & is_store & misal;
    assign stall    = go | (state == BUSY);
    assign tmo      = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);

    always_comb begin
        be_n    = ~is_store ? 4'b0000 : sz_w ? 4'b1111 : sz_h ? (m_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << m_addr[1:0];
        wdata_n = sz_w ? m_wdata : sz_h ? {2{m_wdata[15:0]}} : {4{m_wdata[7:0]}};
        // byte/halfword lanes line up with a shift by 8*addr[1:0]
        shifted = dm_rdata >> {lane, 3'b000};
        fmt     = sz == 2'b11 ? dm_rdata :
                  sz == 2'b01 ? {{16{sgn & shifted[15]}}, shifted[15:0]} :
                                {{24{sgn & shifted[7]}}, shifted[7:0]};
    end

    always_comb begin
        state_n = state;
        if (go)
            state_n = BUSY;
        else if (state == BUSY && (dm_ack || tmo))
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dm_req   <= 1'b0;
            dm_be    <= 4'b0;
            dm_addr  <= '0;
            dm_wdata <= 32'b0;
            ld_data  <= 32'b0;
            exc_bus  <= 1'b0;
            cnt      <= '0;
            lane     <= 2'b0;
            sz       <= 2'b0;
            sgn      <= 1'b0;
            ld_op    <= 1'b0;
        end else begin
            state   <= state_n;
            exc_bus <= 1'b0;
            if (go) begin
                dm_req   <= 1'b1;
                dm_be    <= be_n;
                dm_addr  <= {m_addr[ADDR_W-1:2], 2'b00};
                dm_wdata <= wdata_n;
                lane     <= m_addr[1:0];
                sz       <= op[1:0];
                sgn      <= ~op[2];
                ld_op    <= is_load;
                cnt      <= '0;
            end else if (state == BUSY) begin
                if (dm_ack) begin
                    dm_req <= 1'b0;
                    dm_be  <= 4'b0;
                    if (ld_op)
                        ld_data <= fmt;
                end else if (tmo) begin
                    exc_bus <= 1'b1;
                    dm_req  <= 1'b0;
                    dm_be   <= 4'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// tb_mem_stage_access_ctrl: directed + random load/store traffic; a scoreboard of
// expected transactions is consumed by an independent monitor on the falling edge.
module tb_mem_stage_access_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR, m_addr, m_wdata, dm_rdata;
    logic        m_valid, dm_ack, pres;
    logic        dm_req, stall, exc_adel, exc_ades, exc_bus;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, ld_data;
    logic        t_req, t_stall, t_adel, t_ades, t_bus;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata, t_ld;
    logic        to_ack = 1'b0;

    int checks = 0, errors = 0;
    logic [31:0] exp_ld;

    typedef struct {
        logic        issue, adel, ades, st, tmo;
        logic [3:0]  be;
        logic [31:0] addr, wdata, ld_pre, ld;
        int          stall;
    } rec_t;
    rec_t sb[$];
    rec_t cur;
    logic busy = 1'b0, req_q = 1'b0;
    int   run = 0;

    mem_stage_access_ctrl u_dut (
        .clk(clk), .reset(reset), .IR(IR), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .dm_req(dm_req), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .ld_data(ld_data),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus));

    mem_stage_access_ctrl #(.TIMEOUT(4)) u_to (
        .clk(clk), .reset(reset), .IR(IR), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .dm_req(t_req), .dm_be(t_be), .dm_addr(t_addr), .dm_wdata(t_wdata),
        .dm_rdata(dm_rdata), .dm_ack(to_ack), .stall(t_stall), .ld_data(t_ld),
        .exc_adel(t_adel), .exc_ades(t_ades), .exc_bus(t_bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
        end
    endtask

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100,
                           LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    // reference model: access size/sign from the opcode table, everything else by arithmetic
    task automatic do_op(input logic [5:0] op, input logic v, input logic [31:0] a, w,
                         input int d, input logic [31:0] r);
        rec_t e;
        int size = 0;
        logic ld = 0, st = 0, sgn = 0, mis = 0;
        logic [31:0] mask, val;
        case (op)
            LB:  begin ld = 1; size = 1; sgn = 1; end
            LH:  begin ld = 1; size = 2; sgn = 1; end
            LW:  begin ld = 1; size = 4; end
            LBU: begin ld = 1; size = 1; end
            LHU: begin ld = 1; size = 2; end
            SB:  begin st = 1; size = 1; end
            SH:  begin st = 1; size = 2; end
            SW:  begin st = 1; size = 4; end
            default: ;
        endcase
        if (size != 0) mis = (int'(a[1:0]) % size) != 0;
        e.issue = v && (ld || st) && !mis;
        e.adel  = v && ld && mis;
        e.ades  = v && st && mis;
        e.st    = st;
        e.tmo   = 1'b0;
        e.addr  = a & 32'hFFFF_FFFC;
        e.be    = st ? 4'(((32'd1 << size) - 1) << a[1:0]) : 4'd0;
        e.wdata = size == 4 ? w : size == 2 ? w[15:0] * 32'h0001_0001 : w[7:0] * 32'h0101_0101;
        mask    = size == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
        val     = (r >> (8 * a[1:0])) & mask;
        if (sgn && ((val >> (8 * size - 1)) & 1) != 0) val = val | ~mask;
        e.ld_pre = exp_ld;
        if (e.issue && ld) exp_ld = val;
        e.ld    = exp_ld;
        e.stall = d + 2;
        sb.push_back(e);
        @(posedge clk); #1;
        IR = {op, 26'($urandom)}; m_valid = v; m_addr = a; m_wdata = w; pres = 1'b1;
        dm_rdata = $urandom; dm_ack = e.issue ? 1'b0 : 1'($urandom);
        if (e.issue) begin
            @(posedge clk); #1;
            pres = 1'b0;
            repeat (d) begin
                m_valid = 1'($urandom);
                dm_rdata = $urandom;
                @(posedge clk); #1;
            end
            dm_ack = 1'b1; dm_rdata = r;
            @(posedge clk); #1;
            dm_ack = 1'b0; dm_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        pres = 1'b0; m_valid = 1'b0; dm_ack = 1'b0; reset = 1'b1; exp_ld = 32'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // TIMEOUT=4 instance times out after 4 BUSY cycles; default instance after 16
    task automatic timeout_test();
        rec_t e;
        e.issue = 1; e.adel = 0; e.ades = 0; e.st = 1; e.tmo = 1;
        e.be = 4'hF; e.addr = 32'h40; e.wdata = 32'hCAFE_F00D;
        e.ld_pre = exp_ld; e.ld = exp_ld; e.stall = 17;
        sb.push_back(e);
        @(posedge clk); #1;
        IR = {SW, 26'd0}; m_addr = 32'h40; m_wdata = 32'hCAFE_F00D; m_valid = 1'b1; pres = 1'b1; dm_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("to_stall[%0d]", i), 32'(t_stall), 32'(i < 5));
            chk($sformatf("to_bus[%0d]", i), 32'(t_bus), 32'(i == 5));
            chk($sformatf("to_req[%0d]", i), 32'(t_req), 32'(i >= 1 && i <= 4));
            @(posedge clk); #1;
            pres = 1'b0;
            if (i == 5) m_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_req", 32'(dm_req), 0);
                chk("rst_be", 32'(dm_be), 0);
                chk("rst_addr", dm_addr, 0);
                chk("rst_wdata", dm_wdata, 0);
                chk("rst_ld", ld_data, 0);
                chk("rst_bus", 32'(exc_bus), 0);
                busy = 0; req_q = 0; run = 0;
                continue;
            end
            if (pres) begin
                if (busy) chk("incomplete_access", 32'(busy), 0);
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'(sb.size()), 1);
                end else begin
                    cur = sb.pop_front();
                    chk("exc_adel", 32'(exc_adel), 32'(cur.adel));
                    chk("exc_ades", 32'(exc_ades), 32'(cur.ades));
                    chk("idle_stall", 32'(stall), 32'(cur.issue));
                    chk("idle_ld", ld_data, cur.ld_pre);
                    chk("idle_bus", 32'(exc_bus), 0);
                    busy = cur.issue; run = 0;
                end
            end
            if (busy) begin
                if (stall) run++;
                if (dm_req) begin
                    chk(req_q ? "hold_addr" : "req_addr", dm_addr, cur.addr);
                    chk(req_q ? "hold_be" : "req_be", 32'(dm_be), 32'(cur.be));
                    if (cur.st) chk(req_q ? "hold_wdata" : "req_wdata", dm_wdata, cur.wdata);
                end else if (req_q) begin
                    chk("done_bus", 32'(exc_bus), 32'(cur.tmo));
                    chk("done_stall", 32'(stall), 0);
                    chk("done_be", 32'(dm_be), 0);
                    chk("stall_cycles", 32'(run), 32'(cur.stall));
                    chk("ld_data", ld_data, cur.ld);
                    busy = 0;
                end
            end else if (dm_req && !req_q) begin
                chk("spurious_req", 32'(dm_req), 0);
            end
            req_q = dm_req;
        end
    end

    initial begin
        logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        logic [5:0] op;
        int k;
        reset = 1'b1; IR = 32'b0; m_valid = 1'b0; m_addr = 32'b0; m_wdata = 32'b0;
        dm_rdata = 32'b0; dm_ack = 1'b0; pres = 1'b0; exp_ld = 32'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        do_op(SW, 1, 32'h104, 32'hDEAD_BEEF, 0, 32'h0);
        do_op(SB, 1, 32'h103, 32'h0000_00A5, 0, 32'h0);
        do_op(SH, 1, 32'h102, 32'h0000_1234, 1, 32'h0);
        do_op(LB, 1, 32'h101, 32'h0, 0, 32'h1122_8033);
        do_op(LBU, 1, 32'h101, 32'h0, 2, 32'h1122_8033);
        do_op(LH, 1, 32'h102, 32'h0, 0, 32'h1122_8033);
        do_op(LW, 1, 32'h200, 32'h0, 5, 32'h8765_4321);
        do_op(LW, 1, 32'h202, 32'h0, 0, 32'h0);
        do_op(SH, 1, 32'h101, 32'h0, 0, 32'h0);
        do_op(SW, 0, 32'h104, 32'h1, 0, 32'h0);
        do_op(6'b000000, 1, 32'h104, 32'h1, 0, 32'h0);
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            op = k < 8 ? ops[k] : 6'($urandom);
            do_op(op, ($urandom % 8) != 0, $urandom, $urandom, $urandom_range(0, 6), $urandom);
        end
        do_reset();
        timeout_test();
        @(posedge clk); #1;
        IR = {LW, 26'd0}; m_addr = 32'h300; m_valid = 1'b1; pres = 1'b1; dm_ack = 1'b0;
        sb.push_back('{issue: 1, adel: 0, ades: 0, st: 0, tmo: 0, be: 4'h0, addr: 32'h300,
                       wdata: 32'h0, ld_pre: exp_ld, ld: exp_ld, stall: 2});
        @(posedge clk); #1;
        pres = 1'b0;
        #2;
        chk("busy_req_before_reset", 32'(dm_req), 1);
        reset = 1'b1;
        #1;
        chk("async_reset_req", 32'(dm_req), 0);
        chk("async_reset_be", 32'(dm_be), 0);
        m_valid = 1'b0; exp_ld = 32'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", 32'(stall), 0);
        chk("post_reset_req", 32'(dm_req), 0);
        do_op(LHU, 1, 32'h502, 32'h0, 1, 32'hBEEF_0000);
        m_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("monitor_idle", 32'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
